program_loader: RTL and testbench

Writer-side front end for the main memory that the processor's fetch path reads from. It accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit words. Each word is written to byte-addressed memory at consecutive even addresses, matching the memory's {addr+1, addr} word pairing. The block holds the processor in reset until a complete program has loaded and its checksum has passed.

---
 rtl/program_loader_if.sv | 9 +
 rtl/program_loader.sv | 153 +++++++++++++++
 tb/tb_program_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte stream handshake into the program loader.
interface program_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into memory as
// little-endian 16-bit words and holds the CPU in reset until it verifies.
//
// state   | meaning
// IDLE    | waiting for the first start after reset
// LEN_LO  | accepting word count low byte
// LEN_HI  | accepting word count high byte, range check
// DATA_LO | accepting payload low byte
// DATA_HI | accepting payload high byte
// WRITE   | single-cycle memory write strobe
// CHECK   | accepting and comparing the checksum byte
// DONE    | image verified, CPU released
// ERROR   | load aborted, error_code valid
module program_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  program_loader_if.slave       stream,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code,
  output logic [15:0]           words_written
);

  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [16:0]           MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        xfer;
  logic [15:0] len;
  logic [15:0] index;
  logic [7:0]  checksum;
  logic [7:0]  lo_byte;
  logic [15:0] len_in;
  logic        len_over;
  logic        last_word;

  assign stream.in_ready = accept;
  assign xfer            = accept & stream.in_valid;
  assign len_in          = {stream.in_data, len[7:0]};
  assign len_over        = {1'b0, len_in} > MAX_LEN;
  assign last_word       = (index + 16'd1) == len;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LEN_LO;
      LEN_LO:  if (xfer) state_next = LEN_HI;
      LEN_HI:
        if (xfer) begin
          if (len_over)            state_next = ERROR;
          else if (len_in == '0)   state_next = CHECK;
          else                     state_next = DATA_LO;
        end
      DATA_LO: if (xfer) state_next = DATA_HI;
      DATA_HI: if (xfer) state_next = WRITE;
      WRITE:   state_next = last_word ? CHECK : DATA_LO;
      CHECK:
        if (xfer) state_next = (stream.in_data == checksum) ? DONE : ERROR;
      DONE:    if (start) state_next = LEN_LO;
      ERROR:   if (start) state_next = LEN_LO;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status decode depend on state only, never on in_valid.
  always_comb begin
    accept   = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK: accept = 1'b1;
      WRITE:   mem_we = 1'b1;
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len           <= '0;
      index         <= '0;
      checksum      <= '0;
      lo_byte       <= '0;
      mem_addr      <= BASE;
      mem_data      <= '0;
      error_code    <= '0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR:
          if (start) begin
            len           <= '0;
            index         <= '0;
            checksum      <= '0;
            mem_addr      <= BASE;
            error_code    <= '0;
            words_written <= '0;
          end
        LEN_LO:
          if (xfer) len[7:0] <= stream.in_data;
        LEN_HI:
          if (xfer) begin
            len[15:8] <= stream.in_data;
            if (len_over) error_code <= 2'd1;
          end
        DATA_LO:
          if (xfer) begin
            lo_byte  <= stream.in_data;
            checksum <= checksum ^ stream.in_data;
          end
        DATA_HI:
          if (xfer) begin
            mem_data <= {stream.in_data, lo_byte};
            checksum <= checksum ^ stream.in_data;
          end
        WRITE: begin
          index         <= index + 16'd1;
          words_written <= words_written + 16'd1;
          mem_addr      <= mem_addr + ADDR_WIDTH'(2);
        end
        CHECK:
          if (xfer && stream.in_data != checksum) error_code <= 2'd2;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as stimulus
// is chosen and retired by a write monitor.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [1:0]  error_code;
  logic [15:0] words_written;

  program_loader_if sif ();

  program_loader #(.ADDR_WIDTH(16), .BASE_ADDR(0), .MAX_WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stream(sif),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .error_code(error_code), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int writes_seen = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  stim[$];

  // Write monitor: every strobe must match the next queued {addr, data}.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      logic [31:0] e;
      writes_seen++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, required none", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e)
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_data, e[31:16], e[15:0]);
        else pass_cnt++;
      end
      total_cnt++;
      if (sif.in_ready !== 1'b0) $display("FAIL ready_in_write: got %b, required 0", sif.in_ready);
      else pass_cnt++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int n;
    if (bp) begin
      repeat ($urandom_range(0, 3)) begin
        sif.in_valid = 1'b0;
        sif.in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (sif.in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        total_cnt++;
        $display("FAIL byte_timeout: in_ready stayed %b, required 1", sif.in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic send_stim(input bit bp);
    foreach (stim[i]) send_byte(stim[i], bp);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if (n >= 200) $display("FAIL end_timeout: done=%b error=%b, required one set", done, error);
    else pass_cnt++;
  endtask

  task automatic check_done(input string name, input int ww, input int nwrites);
    total_cnt++;
    if ({done, error, cpu_hold, error_code} !== 5'b10000)
      $display("FAIL %s_status: got done=%b error=%b hold=%b code=%0d, required 1 0 0 0",
               name, done, error, cpu_hold, error_code);
    else pass_cnt++;
    total_cnt++;
    if (words_written !== 16'(ww))
      $display("FAIL %s_words: got %0d, required %0d", name, words_written, ww);
    else pass_cnt++;
    total_cnt++;
    if (writes_seen !== nwrites || exp_q.size() != 0)
      $display("FAIL %s_writes: got %0d writes, %0d pending, required %0d, 0",
               name, writes_seen, exp_q.size(), nwrites);
    else pass_cnt++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load_basic(input bit bp);
    writes_seen = 0;
    pulse_start();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0002, 16'hABCD});
    stim = {8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    send_stim(bp);
    wait_end();
  endtask

  task automatic test_reset();
    start = 1'b0; sif.in_valid = 1'b0; sif.in_data = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total_cnt++;
    if ({sif.in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, error_code, words_written}
        !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0})
      $display("FAIL reset_values: got ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b code=%0d ww=%0d",
               sif.in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, error_code, words_written);
    else pass_cnt++;
    // A byte offered in IDLE must not be consumed.
    sif.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (sif.in_ready !== 1'b0) $display("FAIL idle_ready: got %b, required 0", sif.in_ready);
    else pass_cnt++;
    sif.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    load_basic(1'b0);
    check_done("basic", 2, 2);
  endtask

  task automatic test_zero_length();
    writes_seen = 0;
    pulse_start();
    total_cnt++;
    if ({cpu_hold, done} !== 2'b10)
      $display("FAIL restart_hold: got hold=%b done=%b, required 1 0", cpu_hold, done);
    else pass_cnt++;
    stim = {8'h00, 8'h00, 8'h00};
    send_stim(1'b0);
    wait_end();
    check_done("zero", 0, 0);
  endtask

  task automatic test_bad_checksum();
    writes_seen = 0;
    pulse_start();
    exp_q.push_back({16'h0000, 16'h00FF});
    stim = {8'h01, 8'h00, 8'hFF, 8'h00, 8'h00};
    send_stim(1'b0);
    wait_end();
    total_cnt++;
    if ({done, error, cpu_hold, error_code} !== 5'b01110)
      $display("FAIL badsum_status: got done=%b error=%b hold=%b code=%0d, required 0 1 1 2",
               done, error, cpu_hold, error_code);
    else pass_cnt++;
    total_cnt++;
    if (writes_seen !== 1 || exp_q.size() != 0)
      $display("FAIL badsum_writes: got %0d, required 1", writes_seen);
    else pass_cnt++;
  endtask

  task automatic test_oversize();
    writes_seen = 0;
    pulse_start();
    stim = {8'h05, 8'h00};
    send_stim(1'b0);
    total_cnt++;
    if ({error, error_code, cpu_hold} !== 4'b1011)
      $display("FAIL oversize_status: got error=%b code=%0d hold=%b, required 1 1 1",
               error, error_code, cpu_hold);
    else pass_cnt++;
    sif.in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (sif.in_ready !== 1'b0 || writes_seen !== 0 || words_written !== 16'd0)
      $display("FAIL oversize_idle: got ready=%b writes=%0d ww=%0d, required 0 0 0",
               sif.in_ready, writes_seen, words_written);
    else pass_cnt++;
    sif.in_valid = 1'b0;
  endtask

  task automatic test_max_length();
    writes_seen = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) exp_q.push_back({16'(2 * i), 16'(i + 1)});
    stim = {8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h04};
    send_stim(1'b0);
    wait_end();
    check_done("maxlen", 4, 4);
  endtask

  task automatic test_backpressure();
    load_basic(1'b1);
    check_done("backpressure", 2, 2);
  endtask

  task automatic test_back_to_back();
    // Start pulses mid-load must be ignored.
    writes_seen = 0;
    pulse_start();
    exp_q.push_back({16'h0000, 16'h5A3C});
    stim = {8'h01, 8'h00, 8'h3C};
    send_stim(1'b0);
    pulse_start();
    stim = {8'h5A, 8'h66};
    send_stim(1'b0);
    wait_end();
    check_done("back_to_back", 1, 1);
  endtask

  task automatic test_reset_midload();
    int n;
    writes_seen = 0;
    pulse_start();
    exp_q.push_back({16'h0000, 16'h1234});
    stim = {8'h02, 8'h00, 8'h34, 8'h12};
    send_stim(1'b0);
    n = 0;
    while (writes_seen == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    apply_reset();
    total_cnt++;
    if ({cpu_hold, done, error, sif.in_ready, words_written} !== {4'b1000, 16'd0})
      $display("FAIL midreset: got hold=%b done=%b err=%b ready=%b ww=%0d, required 1 0 0 0 0",
               cpu_hold, done, error, sif.in_ready, words_written);
    else pass_cnt++;
    load_basic(1'b0);
    check_done("reload", 2, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_bad_checksum();
    test_oversize();
    test_max_length();
    test_backpressure();
    test_back_to_back();
    test_reset_midload();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end
endmodule
